// File: rtl/pipe_mux_pkg.sv
// Shared constants and helpers for the pipelined N:1 mux tree.
package pipe_mux_pkg;

    localparam int DEF_WIDTH    = 16;
    localparam int DEF_CHANNELS = 4;
    localparam int COUNT_W      = 16;

    // Ceiling log2; a power-of-two channel count gives the exact tree depth.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pipe_mux_tree_if.sv
// Input stream, output stream and (with PIPE_MUX_COUNT_EN) counter read port
// of the pipelined mux tree, bundled with master/slave views.
interface pipe_mux_tree_if
    import pipe_mux_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS
);
    localparam int LEVELS = clog2(CHANNELS);

    logic [CHANNELS*WIDTH-1:0] io_in_data;
    logic [LEVELS-1:0]         io_in_sel;
    logic                      io_in_valid;
    logic                      io_in_ready;
    logic [WIDTH-1:0]          io_out_data;
    logic [LEVELS-1:0]         io_out_sel;
    logic                      io_out_valid;
    logic                      io_out_ready;
`ifdef PIPE_MUX_COUNT_EN
    logic [LEVELS-1:0]         io_count_sel;
    logic [COUNT_W-1:0]        io_count;
`endif

    modport slave (
        input  io_in_data, io_in_sel, io_in_valid, io_out_ready,
        output io_in_ready, io_out_data, io_out_sel, io_out_valid
`ifdef PIPE_MUX_COUNT_EN
        , input io_count_sel, output io_count
`endif
    );

    modport master (
        output io_in_data, io_in_sel, io_in_valid, io_out_ready,
        input  io_in_ready, io_out_data, io_out_sel, io_out_valid
`ifdef PIPE_MUX_COUNT_EN
        , output io_count_sel, input io_count
`endif
    );

endinterface

// File: rtl/pipe_mux_stage.sv
// One registered level of the mux tree: halves the word count using sel bit
// LEVEL and carries the full sel along with the item.
module pipe_mux_stage #(
    parameter int WIDTH = 16,
    parameter int N_IN  = 4,
    parameter int LEVEL = 0,
    parameter int SEL_W = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [N_IN*WIDTH-1:0]       up_data,
    input  logic [SEL_W-1:0]            up_sel,
    input  logic                        up_valid,
    output logic                        up_ready,
    output logic [(N_IN/2)*WIDTH-1:0]   dn_data,
    output logic [SEL_W-1:0]            dn_sel,
    output logic                        dn_valid,
    input  logic                        dn_ready
);
    localparam int N_OUT = N_IN / 2;

    logic [N_OUT*WIDTH-1:0] mux_data;
    logic [N_OUT*WIDTH-1:0] data_q, data_d;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic                   valid_q, valid_d;
    logic                   load;

    always_comb begin
        mux_data = '0;
        for (int i = 0; i < N_OUT; i++) begin
            mux_data[i*WIDTH +: WIDTH] = up_sel[LEVEL] ? up_data[(2*i+1)*WIDTH +: WIDTH]
                                                       : up_data[(2*i)*WIDTH +: WIDTH];
        end
    end

    // NOTE: every variable gets its hold value first so no path infers a latch.
    always_comb begin
        load    = !valid_q || dn_ready;
        valid_d = valid_q;
        data_d  = data_q;
        sel_d   = sel_q;
        if (load) begin
            valid_d = up_valid;
            // Payload only moves with a real item, so idle bubbles never disturb the output.
            if (up_valid) begin
                data_d = mux_data;
                sel_d  = up_sel;
            end
        end
    end

    // NOTE: non-blocking assignments make every flop sample pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sel_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
        end
    end

    assign up_ready = load;
    assign dn_data  = data_q;
    assign dn_sel   = sel_q;
    assign dn_valid = valid_q;

endmodule

// File: rtl/pipe_mux_tree.sv
// Pipelined CHANNELS:1 mux tree with valid/ready flow control, one registered
// level per sel bit. Define PIPE_MUX_COUNT_EN for per-channel transfer counters.
module pipe_mux_tree
    import pipe_mux_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS
) (
    input  logic            clock,
    input  logic            reset,
    pipe_mux_tree_if.slave  bus
);
    localparam int LEVELS = clog2(CHANNELS);

    genvar k;
    generate
        for (k = 0; k < LEVELS; k++) begin : g_lvl
            localparam int N_IN = CHANNELS >> k;

            logic [N_IN*WIDTH-1:0]     up_data;
            logic [LEVELS-1:0]         up_sel;
            logic                      up_valid;
            logic                      up_ready;
            logic [(N_IN/2)*WIDTH-1:0] dn_data;
            logic [LEVELS-1:0]         dn_sel;
            logic                      dn_valid;
            logic                      dn_ready;

            if (k == 0) begin : g_head
                assign up_data         = bus.io_in_data;
                assign up_sel          = bus.io_in_sel;
                assign up_valid        = bus.io_in_valid;
                assign bus.io_in_ready = up_ready;
            end else begin : g_link
                assign up_data  = g_lvl[k-1].dn_data;
                assign up_sel   = g_lvl[k-1].dn_sel;
                assign up_valid = g_lvl[k-1].dn_valid;
            end

            // The ready chain is combinational end to end so a full tree still streams 1/cycle.
            if (k == LEVELS - 1) begin : g_tail
                assign dn_ready         = bus.io_out_ready;
                assign bus.io_out_data  = dn_data;
                assign bus.io_out_sel   = dn_sel;
                assign bus.io_out_valid = dn_valid;
            end else begin : g_feed
                assign dn_ready = g_lvl[k+1].up_ready;
            end

            pipe_mux_stage #(
                .WIDTH (WIDTH),
                .N_IN  (N_IN),
                .LEVEL (k),
                .SEL_W (LEVELS)
            ) u_stage (
                .clock    (clock),
                .reset    (reset),
                .up_data  (up_data),
                .up_sel   (up_sel),
                .up_valid (up_valid),
                .up_ready (up_ready),
                .dn_data  (dn_data),
                .dn_sel   (dn_sel),
                .dn_valid (dn_valid),
                .dn_ready (dn_ready)
            );
        end
    endgenerate

`ifdef PIPE_MUX_COUNT_EN
    logic [COUNT_W-1:0] count_q [CHANNELS];
    logic [COUNT_W-1:0] count_d [CHANNELS];

    always_comb begin
        count_d = count_q;
        if (bus.io_out_valid && bus.io_out_ready && (count_q[bus.io_out_sel] != '1)) begin
            count_d[bus.io_out_sel] = count_q[bus.io_out_sel] + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) count_q[i] <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.io_count = count_q[bus.io_count_sel];
`endif

endmodule

// File: tb/tb_pipe_mux_tree.sv
// Self-checking bench: a 4-channel/16-bit and an 8-channel/8-bit tree against
// queue-based reference models.
module tb_pipe_mux_tree;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    pipe_mux_tree_if #(.WIDTH(16), .CHANNELS(4)) if4 ();
    pipe_mux_tree_if #(.WIDTH(8),  .CHANNELS(8)) if8 ();

    pipe_mux_tree #(.WIDTH(16), .CHANNELS(4)) u4 (.clock(clock), .reset(reset), .bus(if4.slave));
    pipe_mux_tree #(.WIDTH(8),  .CHANNELS(8)) u8 (.clock(clock), .reset(reset), .bus(if8.slave));

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_all();
        if4.io_in_valid  = 1'b0;
        if4.io_in_sel    = '0;
        if4.io_in_data   = '0;
        if4.io_out_ready = 1'b0;
        if8.io_in_valid  = 1'b0;
        if8.io_in_sel    = '0;
        if8.io_out_ready = 1'b0;
        for (int c = 0; c < 8; c++) if8.io_in_data[c*8 +: 8] = 8'h10 + 8'(c);
`ifdef PIPE_MUX_COUNT_EN
        if4.io_count_sel = '0;
        if8.io_count_sel = '0;
`endif
    endtask

    task automatic test_reset();
        idle_all();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++; if (if4.io_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", if4.io_out_valid); end
        checks++; if (if4.io_out_data !== 16'h0) begin errors++; $display("FAIL reset_out_data got %0h want 0", if4.io_out_data); end
        checks++; if (if4.io_out_sel !== 2'd0) begin errors++; $display("FAIL reset_out_sel got %0d want 0", if4.io_out_sel); end
        checks++; if (if4.io_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", if4.io_in_ready); end
        checks++; if (if8.io_out_valid !== 1'b0) begin errors++; $display("FAIL reset8_out_valid got %0b want 0", if8.io_out_valid); end
        checks++; if (if8.io_in_ready !== 1'b1) begin errors++; $display("FAIL reset8_in_ready got %0b want 1", if8.io_in_ready); end
    endtask

    task automatic test_single();
        logic [63:0] words;
        words = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        if4.io_in_data   = words;
        if4.io_in_sel    = 2'd2;
        if4.io_in_valid  = 1'b1;
        if4.io_out_ready = 1'b1;
        #1;
        checks++; if (if4.io_in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready got %0b want 1", if4.io_in_ready); end
        tick();
        if4.io_in_valid = 1'b0;
        if4.io_in_data  = {$urandom, $urandom};
        if4.io_in_sel   = 2'($urandom);
        checks++; if (if4.io_out_valid !== 1'b0) begin errors++; $display("FAIL single_early got %0b want 0", if4.io_out_valid); end
        tick();
        checks++; if (if4.io_out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", if4.io_out_valid); end
        checks++; if (if4.io_out_data !== words[2*16 +: 16]) begin errors++; $display("FAIL single_data got %0h want %0h", if4.io_out_data, words[2*16 +: 16]); end
        checks++; if (if4.io_out_sel !== 2'd2) begin errors++; $display("FAIL single_sel got %0d want 2", if4.io_out_sel); end
        tick();
        checks++; if (if4.io_out_valid !== 1'b0) begin errors++; $display("FAIL single_after got %0b want 0", if4.io_out_valid); end
    endtask

    task automatic test_streaming();
        logic [63:0] words;
        logic        exp_valid;
        words = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        if4.io_in_data   = words;
        if4.io_out_ready = 1'b1;
        for (int e = 0; e < 7; e++) begin
            if4.io_in_valid = (e < 4);
            if4.io_in_sel   = 2'(e);
            #1;
            if (e < 4) begin
                checks++; if (if4.io_in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d] got %0b want 1", e, if4.io_in_ready); end
            end
            tick();
            exp_valid = (e >= 1) && (e <= 4);
            checks++; if (if4.io_out_valid !== exp_valid) begin errors++; $display("FAIL stream_valid[%0d] got %0b want %0b", e, if4.io_out_valid, exp_valid); end
            if (exp_valid) begin
                checks++; if (if4.io_out_data !== words[(e-1)*16 +: 16]) begin errors++; $display("FAIL stream_data[%0d] got %0h want %0h", e, if4.io_out_data, words[(e-1)*16 +: 16]); end
                checks++; if (if4.io_out_sel !== 2'(e-1)) begin errors++; $display("FAIL stream_sel[%0d] got %0d want %0d", e, if4.io_out_sel, e-1); end
            end
        end
        if4.io_in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [15:0] exp_q[$];
        logic [1:0]  sel_q[$];
        logic [63:0] words;
        logic [1:0]  sel;
        int          accepted;
        accepted = 0;
        if4.io_out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            words = {$urandom, $urandom};
            sel   = 2'($urandom_range(0, 3));
            if4.io_in_data  = words;
            if4.io_in_sel   = sel;
            if4.io_in_valid = 1'b1;
            #1;
            if (if4.io_in_ready) begin
                exp_q.push_back(words[sel*16 +: 16]);
                sel_q.push_back(sel);
                accepted++;
            end
            tick();
            if (c >= 1 && exp_q.size() > 0) begin
                checks++; if (if4.io_out_valid !== 1'b1 || if4.io_out_data !== exp_q[0]) begin
                    errors++; $display("FAIL bp_hold[%0d] got v=%0b d=%0h want v=1 d=%0h", c, if4.io_out_valid, if4.io_out_data, exp_q[0]);
                end
            end
        end
        #1;
        checks++; if (accepted != 2) begin errors++; $display("FAIL bp_accepted got %0d want 2", accepted); end
        checks++; if (if4.io_in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %0b want 0", if4.io_in_ready); end

        if4.io_out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            words = {$urandom, $urandom};
            sel   = 2'($urandom_range(0, 3));
            if4.io_in_data  = words;
            if4.io_in_sel   = sel;
            if4.io_in_valid = (c < 6);
            #1;
            if (c < 6) begin
                checks++; if (if4.io_in_ready !== 1'b1) begin errors++; $display("FAIL drain_in_ready[%0d] got %0b want 1", c, if4.io_in_ready); end
            end
            if (if4.io_out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL drain_extra[%0d] got d=%0h want none", c, if4.io_out_data);
                end else begin
                    if (if4.io_out_data !== exp_q[0] || if4.io_out_sel !== sel_q[0]) begin
                        errors++; $display("FAIL drain_item[%0d] got d=%0h s=%0d want d=%0h s=%0d", c, if4.io_out_data, if4.io_out_sel, exp_q[0], sel_q[0]);
                    end
                    void'(exp_q.pop_front());
                    void'(sel_q.pop_front());
                end
            end
            if (if4.io_in_valid && if4.io_in_ready) begin
                exp_q.push_back(words[sel*16 +: 16]);
                sel_q.push_back(sel);
            end
            tick();
        end
        if4.io_in_valid = 1'b0;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL drain_left got %0d want 0", exp_q.size()); end
        checks++; if (if4.io_out_valid !== 1'b0) begin errors++; $display("FAIL drain_idle got %0b want 0", if4.io_out_valid); end
    endtask

    task automatic test_reset_midflight();
        int stale;
        stale = 0;
        if4.io_out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            if4.io_in_data  = {$urandom | 32'h1, $urandom | 32'h1};
            if4.io_in_sel   = 2'(c + 1);
            if4.io_in_valid = 1'b1;
            tick();
        end
        if4.io_in_valid = 1'b0;
        checks++; if (if4.io_out_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre got %0b want 1", if4.io_out_valid); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (if4.io_out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %0b want 0", if4.io_out_valid); end
        checks++; if (if4.io_out_data !== 16'h0) begin errors++; $display("FAIL midrst_data got %0h want 0", if4.io_out_data); end
        if4.io_out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (if4.io_out_valid !== 1'b0) stale++;
        end
        checks++; if (stale != 0) begin errors++; $display("FAIL midrst_stale got %0d want 0", stale); end
    endtask

    task automatic test_cfg8();
        logic [7:0] exp_q[$];
        logic [2:0] sel_q[$];
        logic [2:0] sel;
        int         n_in;
        int         n_out;
        n_in  = 0;
        n_out = 0;
        if8.io_out_ready = 1'b1;
        if8.io_in_sel    = 3'd5;
        if8.io_in_valid  = 1'b1;
        tick();
        if8.io_in_valid = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            checks++; if (if8.io_out_valid !== (e == 3)) begin errors++; $display("FAIL lat8[%0d] got %0b want %0b", e, if8.io_out_valid, e == 3); end
            if (e < 3) tick();
        end
        checks++; if (if8.io_out_data !== 8'h15 || if8.io_out_sel !== 3'd5) begin
            errors++; $display("FAIL lat8_item got d=%0h s=%0d want d=15 s=5", if8.io_out_data, if8.io_out_sel);
        end
        tick();

        for (int c = 0; c < 450; c++) begin
            sel = 3'($urandom_range(0, 7));
            if8.io_in_sel    = sel;
            if8.io_in_valid  = (c < 400) && ($urandom_range(0, 3) != 0);
            if8.io_out_ready = (c >= 400) || ($urandom_range(0, 2) != 0);
            #1;
            if (if8.io_out_valid && if8.io_out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL sb8_extra[%0d] got d=%0h want none", c, if8.io_out_data);
                end else begin
                    if (if8.io_out_data !== exp_q[0] || if8.io_out_sel !== sel_q[0]) begin
                        errors++; $display("FAIL sb8_item[%0d] got d=%0h s=%0d want d=%0h s=%0d", c, if8.io_out_data, if8.io_out_sel, exp_q[0], sel_q[0]);
                    end
                    void'(exp_q.pop_front());
                    void'(sel_q.pop_front());
                end
                n_out++;
            end
            if (if8.io_in_valid && if8.io_in_ready) begin
                exp_q.push_back(8'h10 + 8'(sel));
                sel_q.push_back(sel);
                n_in++;
            end
            tick();
        end
        if8.io_in_valid = 1'b0;
        checks++; if (n_out != n_in || exp_q.size() != 0) begin
            errors++; $display("FAIL sb8_count got out=%0d in=%0d left=%0d want equal and 0", n_out, n_in, exp_q.size());
        end
    endtask

`ifdef PIPE_MUX_COUNT_EN
    task automatic test_count();
        int seq[8] = '{1, 3, 1, 1, 3, 1, 3, 1};
        idle_all();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        if4.io_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if4.io_in_sel   = 2'(seq[i]);
            if4.io_in_valid = 1'b1;
            tick();
        end
        if4.io_in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        if4.io_count_sel = 2'd1; #1;
        checks++; if (if4.io_count !== 16'd5) begin errors++; $display("FAIL count_ch1 got %0d want 5", if4.io_count); end
        if4.io_count_sel = 2'd3; #1;
        checks++; if (if4.io_count !== 16'd3) begin errors++; $display("FAIL count_ch3 got %0d want 3", if4.io_count); end
        if4.io_count_sel = 2'd0; #1;
        checks++; if (if4.io_count !== 16'd0) begin errors++; $display("FAIL count_ch0 got %0d want 0", if4.io_count); end
        if4.io_in_sel   = 2'd0;
        if4.io_in_valid = 1'b1;
        for (int i = 0; i < 65536; i++) tick();
        if4.io_in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++; if (if4.io_count !== 16'hFFFF) begin errors++; $display("FAIL count_sat got %0h want ffff", if4.io_count); end
        if4.io_count_sel = 2'd1; #1;
        checks++; if (if4.io_count !== 16'd5) begin errors++; $display("FAIL count_ch1_hold got %0d want 5", if4.io_count); end
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_streaming();
        test_backpressure();
        test_reset_midflight();
        test_cfg8();
`ifdef PIPE_MUX_COUNT_EN
        test_count();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
